// File: rtl/seg_scan_if.sv
// Bundle of the display-register load path and the scanned digit outputs
// exchanged between a host and the 4-digit 7-segment scanner.
interface seg_scan_if;
    logic        load;
    logic [15:0] din;
    logic        blank_lz;
    logic [3:0]  x;
    logic [3:0]  dig_en;
    logic        frame;

    modport master (
        output load,
        output din,
        output blank_lz,
        input  x,
        input  dig_en,
        input  frame
    );

    modport slave (
        input  load,
        input  din,
        input  blank_lz,
        output x,
        output dig_en,
        output frame
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Presents one nibble of the held 16-bit value at a time on x (for dec7seg),
// with a one-hot digit enable, optional leading-zero blanking and a frame
// pulse at the start of each new scan.
module seg_scan_mux #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    // Prescaler needs at least one bit even when DIV is 1.
    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   val;
    logic          frame_q;
    logic          slot_end;
    logic          blank;
    logic [3:0]    nib;

    assign slot_end = (presc == PRESC_MAX);

    // Prescaler, digit index, display register and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= 2'd0;
            val     <= 16'h0000;
            frame_q <= 1'b0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            // Pulse in the first cycle of digit 0's slot after a full scan.
            frame_q <= slot_end && (idx == 2'd3);
            if (bus.load) begin
                val <= bus.din;
            end
        end
    end

    // Active nibble and leading-zero blanking decision for the current slot.
    always_comb begin
        nib   = val[4*idx +: 4];
        blank = 1'b0;
        if (bus.blank_lz) begin
            case (idx)
                2'd1:    blank = (val[15:4]  == 12'h000);
                2'd2:    blank = (val[15:8]  == 8'h00);
                2'd3:    blank = (val[15:12] == 4'h0);
                default: blank = 1'b0;  // digit 0 always shows, so 0 reads "0"
            endcase
        end
    end

    assign bus.x      = blank ? 4'h0 : nib;
    assign bus.dig_en = blank ? 4'b0000 : (4'b0001 << idx);
    assign bus.frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed, table-driven bench for seg_scan_mux with DIV=4.
module tb_seg_scan_mux;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seg_scan_if bus();

    seg_scan_mux #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [15:0] din;
        logic        blank;
        int          steps;
        logic [3:0]  ex;
        logic [3:0]  een;
        logic        efr;
    } vec_t;

    vec_t tbl[23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ex, input logic [3:0] een, input logic efr);
        chk({tag, ".x"}, {12'h0, bus.x}, {12'h0, ex});
        chk({tag, ".dig_en"}, {12'h0, bus.dig_en}, {12'h0, een});
        chk({tag, ".frame"}, {15'h0, bus.frame}, {15'h0, efr});
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.din      = 16'h0000;
        bus.blank_lz = 1'b0;

        // Scan position c counts cycles since reset; idx=(c/4)%4, frame at c%16==0, c>0.
        tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1, 4'h4, 4'b0001, 1'b0};  // c=1
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 3, 4'h3, 4'b0010, 1'b0};  // c=4
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 4, 4'h2, 4'b0100, 1'b0};  // c=8
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 4, 4'h1, 4'b1000, 1'b0};  // c=12
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 3, 4'h1, 4'b1000, 1'b0};  // c=15
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1, 4'h4, 4'b0001, 1'b1};  // c=16 frame
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1, 4'h4, 4'b0001, 1'b0};  // c=17
        tbl[7]  = '{1'b1, 16'h0042, 1'b1, 1, 4'h2, 4'b0001, 1'b0};  // c=18
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 2, 4'h4, 4'b0010, 1'b0};  // c=20
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0000, 1'b0};  // c=24 blank
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0000, 1'b0};  // c=28 blank
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 4, 4'h2, 4'b0001, 1'b1};  // c=32 frame
        tbl[12] = '{1'b1, 16'h0000, 1'b1, 1, 4'h0, 4'b0001, 1'b0};  // c=33 val=0
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 3, 4'h0, 4'b0000, 1'b0};  // c=36
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0000, 1'b0};  // c=40
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0000, 1'b0};  // c=44
        tbl[16] = '{1'b1, 16'h1004, 1'b1, 4, 4'h4, 4'b0001, 1'b1};  // c=48 frame
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0010, 1'b0};  // c=52 inner zero
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 4, 4'h0, 4'b0100, 1'b0};  // c=56 inner zero
        tbl[19] = '{1'b0, 16'h0000, 1'b1, 4, 4'h1, 4'b1000, 1'b0};  // c=60
        tbl[20] = '{1'b1, 16'h0042, 1'b0, 4, 4'h2, 4'b0001, 1'b1};  // c=64 frame
        tbl[21] = '{1'b0, 16'h0000, 1'b0, 8, 4'h0, 4'b0100, 1'b0};  // c=72 zero shown
        tbl[22] = '{1'b0, 16'h0000, 1'b1, 0, 4'h0, 4'b0000, 1'b0};  // c=72 blank_lz comb

        // Reset held two cycles, then released.
        step();
        step();
        rst = 1'b0;
        chk_out("reset", 4'h0, 4'b0001, 1'b0);
        step();
        step();
        step();
        chk("reset.hold_slot", {12'h0, bus.dig_en}, 16'h0001);
        step();
        chk("reset.slot_end", {12'h0, bus.dig_en}, 16'h0002);

        // Re-align to c=0.
        rst = 1'b1;
        step();
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            bus.load     = tbl[i].load;
            bus.din      = tbl[i].din;
            bus.blank_lz = tbl[i].blank;
            if (tbl[i].steps == 0) begin
                #1;
            end else begin
                for (int s = 0; s < tbl[i].steps; s++) begin
                    step();
                    bus.load = 1'b0;
                end
            end
            chk_out($sformatf("vec%0d", i), tbl[i].ex, tbl[i].een, tbl[i].efr);
        end

        // Load during digit 1's slot at presc=2.
        bus.blank_lz = 1'b0;
        bus.load     = 1'b1;
        bus.din      = 16'h1234;
        step();                                   // c=73
        bus.load = 1'b0;
        for (int s = 0; s < 13; s++) step();      // c=86: idx1, presc2
        chk_out("midload.before", 4'h3, 4'b0010, 1'b0);
        bus.load = 1'b1;
        bus.din  = 16'hABCD;
        step();                                   // c=87
        bus.load = 1'b0;
        chk_out("midload.after", 4'hC, 4'b0010, 1'b0);
        step();                                   // c=88: idx2
        chk_out("midload.slot_end", 4'hB, 4'b0100, 1'b0);

        // Reset mid-scan during digit 2 with a simultaneous load.
        step();                                   // c=89
        rst      = 1'b1;
        bus.load = 1'b1;
        bus.din  = 16'h5555;
        step();
        rst      = 1'b0;
        bus.load = 1'b0;
        chk_out("midrst", 4'h0, 4'b0001, 1'b0);
        step();
        step();
        step();
        chk("midrst.hold_slot", {12'h0, bus.dig_en}, 16'h0001);
        step();
        chk_out("midrst.next", 4'h0, 4'b0010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
